imem_program_loader: RTL and testbench
======================================

// Module: imem_program_loader
// PURPOSE
//   Writer side of the instruction-memory interface: takes a host word stream (valid/ready) and writes it
//   into instruction memory at consecutive word-aligned byte addresses. Holds the processor in reset while
//   loading, then releases it so fetch starts from PC=0. Sits between host link and imem write port.
// PARAMETERS
//   ADDR_W        8   word-address width; imem depth = 2**ADDR_W words
//   DATA_W        32  instruction width
//   RELEASE_DELAY 4   cycles in HOLD before cpu_reset deasserts (>=1)
// PORTS
//   clk         in   1         clock, all state on rising edge
//   reset       in   1         synchronous, active-high
//   start       in   1         1-cycle pulse: begin (re)load
//   in_valid    in   1         host word valid
//   in_data     in   DATA_W    host word
//   in_last     in   1         marks final program word (qualified by in_valid)
//   in_ready    out  1         loader accepts word this cycle
//   imem_we     out  1         imem write enable
//   imem_addr   out  ADDR_W+2  imem byte address, [1:0] always 2'b00
//   imem_wdata  out  DATA_W    imem write data
//   cpu_reset   out  1         reset to processor, active-high
//   done        out  1         program loaded, processor running
//   err         out  1         load failed (overflow / checksum)
//   word_count  out  ADDR_W+1  program words accepted in current load
// BEHAVIOUR
//   Reset: state=IDLE; cpu_reset=1; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; done=0; err=0;
//     word_count=0. Reset mid-load aborts immediately; no further imem writes.
//   Accept = in_valid & in_ready. in_ready is combinational from state only (1 iff state LOAD/CSUM).
//   FSM: IDLE -start-> LOAD (word_count<=0, err<=0, done<=0, cpu_reset<=1).
//     LOAD: on accept, register imem_we=1, imem_addr={word_count,2'b00}, imem_wdata=in_data (write visible
//       exactly 1 cycle after accept); word_count++. No accept -> imem_we=0 next cycle; gaps allowed.
//     LOAD, accept with in_last -> HOLD (or CSUM if macro on).
//     LOAD, accept at word_count==2**ADDR_W-1 without in_last -> word still written, then ERR (overflow).
//     HOLD: count RELEASE_DELAY cycles, then RUN. RUN: cpu_reset=0, done=1.
//     ERR: err=1, cpu_reset=1, done=0, in_ready=0.
//     start in RUN or ERR -> LOAD; cpu_reset re-asserts the next cycle; word_count restarts at 0.
//     start in LOAD/HOLD/CSUM ignored. in_valid outside LOAD/CSUM ignored (no write, no count).
//   cpu_reset, done, err are registered. Words beyond in_last are never written.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined: running 32-bit sum (mod 2**32) of accepted program words; after in_last
//     FSM enters CSUM, accepts exactly one more word (not written to imem, not counted); equal -> HOLD,
//     differ -> ERR. Sum clears on start.
//   Not defined: no CSUM state, no adder; in_last goes straight to HOLD; err set only by overflow.
// TESTING
//   1 reset, start, 3 words 0x00500093,0x00300113,0x002081B3 (last on 3rd), no gaps -> writes at 0x0,
//     0x4,0x8 each 1 cycle after accept; word_count=3; cpu_reset falls RELEASE_DELAY cycles after HOLD; done=1.
//   2 same program with in_valid low 2 cycles between words -> identical writes, imem_we low in gaps.
//   3 ADDR_W=2, 5 words no in_last -> 4 writes (0x0..0xC), 5th not accepted, err=1, cpu_reset=1.
//   4 reset asserted after 2nd accept -> next cycle all outputs at reset values, no 3rd write.
//   5 in RUN pulse start -> cpu_reset=1 next cycle, done=0; reload 1 word -> write at 0x0.
//   6 macro on: words 1,2 + trailer 3 -> done=1; trailer 4 -> err=1; trailer never written to imem.

Source files
------------

// File: rtl/imem_program_loader.sv
// imem_program_loader: writer side of the instruction-memory interface.
// Accepts a host word stream (valid/ready) and writes it into instruction memory at consecutive
// word-aligned byte addresses, holding the processor in reset until the load is complete and then
// releasing it so fetch starts from PC=0.
//
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, one extra trailer word follows the word
// marked in_last and must equal the 32-bit running sum of the program words, otherwise err is raised.
//
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : synchronous active-high reset
//   start      : 1-cycle pulse, begin (re)load (honoured in idle/run/error only)
//   in_valid   : host word valid
//   in_data    : host word
//   in_last    : final program word marker, qualified by in_valid
//   in_ready   : loader accepts a word this cycle (decoded from state only)
//   imem_we    : imem write enable (registered)
//   imem_addr  : imem byte address, low two bits always zero
//   imem_wdata : imem write data
//   cpu_reset  : active-high processor reset
//   done       : program loaded and processor running
//   err        : load failed (overflow or checksum mismatch)
//   word_count : program words accepted in current load
module imem_program_loader #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W+1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned DlyW = (RELEASE_DELAY < 2) ? 1 : $clog2(RELEASE_DELAY);
  // word_count value at which the final imem slot is being filled
  localparam logic [ADDR_W:0] LastSlot = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [DlyW-1:0] DlyLast  = DlyW'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
`ifdef LOADER_CHECKSUM_EN
    StCsum,
`endif
    StHold,
    StRun,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              we_q, we_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DlyW-1:0]   hold_cnt_q, hold_cnt_d;
  logic              accept;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state_q == StLoad) || (state_q == StCsum);
`else
  assign in_ready = (state_q == StLoad);
`endif
  assign accept = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    err_d        = err_q;
    hold_cnt_d   = hold_cnt_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    unique case (state_q)
      StIdle, StRun, StErr: begin
        if (start) begin
          state_d      = StLoad;
          word_count_d = '0;
          err_d        = 1'b0;
          done_d       = 1'b0;
          cpu_reset_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d        = '0;
`endif
        end
      end
      StLoad: begin
        if (accept) begin
          we_d         = 1'b1;
          addr_d       = {word_count_q[ADDR_W-1:0], 2'b00};
          wdata_d      = in_data;
          word_count_d = word_count_q + CntW'(1);
`ifdef LOADER_CHECKSUM_EN
          sum_d        = sum_q + 32'(in_data);
`endif
          if (in_last) begin
`ifdef LOADER_CHECKSUM_EN
            state_d    = StCsum;
`else
            state_d    = StHold;
`endif
            hold_cnt_d = '0;
          end else if (word_count_q == LastSlot) begin
            // Memory is full and the host still has more: the word just taken is kept, load fails.
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        // Trailer word is compared only; it is neither written nor counted.
        if (accept) begin
          if (32'(in_data) == sum_q) begin
            state_d    = StHold;
            hold_cnt_d = '0;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
`endif
      StHold: begin
        if (hold_cnt_q == DlyLast) begin
          state_d     = StRun;
          cpu_reset_d = 1'b0;
          done_d      = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + DlyW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      word_count_q <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      hold_cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      err_q        <= err_d;
      hold_cnt_q   <= hold_cnt_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader with a 4-word memory (ADDR_W=2).
// Stimulus pushes expected imem writes (address, data, cycle) into a queue; a monitor pops and
// compares whenever imem_we is seen. Control outputs are checked against a simple load model.
module tb_imem_program_loader;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 32;
  localparam int unsigned RD    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct {
    logic [AW+1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_last;
  logic [DW-1:0] in_data;
  logic          in_ready, imem_we, cpu_reset, done, err;
  logic [AW+1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic [AW:0]   word_count;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [31:0] words[$];

  imem_program_loader #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .RELEASE_DELAY(RD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write monitor: every observed write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h required=no write (cycle %0d)",
                 imem_addr, imem_wdata, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(imem_addr), 64'(e.addr));
        chk("wr_data", 64'(imem_wdata), 64'(e.data));
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 0);
    chk({tag, "_imem_we"}, 64'(imem_we), 0);
    chk({tag, "_imem_addr"}, 64'(imem_addr), 0);
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 0);
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 1);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_word_count"}, 64'(word_count), 0);
  endtask

  // Called at posedge+1; returns at posedge+1 with the loader in its load state.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_cpu_reset", 64'(cpu_reset), 1);
    chk("start_done", 64'(done), 0);
    chk("start_err", 64'(err), 0);
    chk("start_word_count", 64'(word_count), 0);
    chk("start_in_ready", 64'(in_ready), 1);
  endtask

  task automatic drive_word(input int idx, input logic [31:0] w, input bit last,
                            input bit exp_acc, input bit exp_wr);
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(exp_acc));
    if (exp_wr) exp_q.push_back('{addr: (AW + 2)'(idx * 4), data: w, cyc: cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_err(input int wc);
    chk("err_err", 64'(err), 1);
    chk("err_cpu_reset", 64'(cpu_reset), 1);
    chk("err_done", 64'(done), 0);
    chk("err_in_ready", 64'(in_ready), 0);
    chk("err_word_count", 64'(word_count), 64'(wc));
    chk("err_writes_drained", 64'(exp_q.size()), 0);
  endtask

  // One complete load of words[0..n-1]. Without in_last, n must exceed DEPTH (overflow case).
  task automatic run_load(input int n, input bit with_last, input int gap_lo, input int gap_hi,
                          input bit good_csum, input bit junk);
    logic [31:0] sum;
    int n_acc;
    sum = '0;
    pulse_start();
    for (int i = 0; i < n; i++) begin
      bit acc;
      acc = (i < int'(DEPTH));
      if (i > 0) begin
        repeat ($urandom_range(gap_hi, gap_lo)) begin
          @(posedge clk);
          #1;
        end
      end
      drive_word(i, words[i], with_last && (i == n - 1), acc, acc);
      if (acc) sum += words[i];
    end
    n_acc = (n < int'(DEPTH)) ? n : int'(DEPTH);
    if (!with_last) begin
      check_err(n_acc);
      return;
    end
`ifdef LOADER_CHECKSUM_EN
    drive_word(0, good_csum ? sum : sum + 32'd1, 1'b0, 1'b1, 1'b0);
    if (!good_csum) begin
      check_err(n_acc);
      return;
    end
`else
    if (good_csum && sum == 32'hFFFF_FFFF) chk("sum_unused", 0, 0);
`endif
    // Hold phase: cpu_reset must stay high for exactly RD cycles after the final accept.
    in_valid = junk;
    in_data  = $urandom;
    in_last  = junk & $urandom_range(1, 0);
    for (int k = 0; k <= int'(RD); k++) begin
      chk("hold_cpu_reset", 64'(cpu_reset), 64'(k < int'(RD)));
      chk("hold_done", 64'(done), 64'(k >= int'(RD)));
      chk("hold_in_ready", 64'(in_ready), 0);
      if (k < int'(RD)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("run_err", 64'(err), 0);
    chk("run_word_count", 64'(word_count), 64'(n_acc));
    chk("run_writes_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals("reset");

    // Reference program, back-to-back, then with 2-cycle gaps.
    words = '{32'h0050_0093, 32'h0030_0113, 32'h0020_81B3};
    run_load(3, 1'b1, 0, 0, 1'b1, 1'b0);
    run_load(3, 1'b1, 2, 2, 1'b1, 1'b0);

    // Restart from the running state with a single-word program.
    words = '{32'hDEAD_BEEF};
    run_load(1, 1'b1, 0, 0, 1'b1, 1'b1);

    // Overflow: five words, no in_last.
    words = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    run_load(5, 1'b0, 0, 0, 1'b1, 1'b0);

    // Reset arriving right after the second accept aborts the load.
    words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    pulse_start();
    drive_word(0, words[0], 1'b0, 1'b1, 1'b1);
    drive_word(1, words[1], 1'b0, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = words[2];
    reset    = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    check_reset_vals("mid_reset");
    @(posedge clk);
    #1;
    chk("mid_reset_drained", 64'(exp_q.size()), 0);

`ifdef LOADER_CHECKSUM_EN
    words = '{32'd1, 32'd2};
    run_load(2, 1'b1, 0, 0, 1'b1, 1'b0);
    run_load(2, 1'b1, 0, 0, 1'b0, 1'b0);
`endif

    // Randomized loads.
    for (int t = 0; t < 30; t++) begin
      int  n;
      bit  wl;
      wl = ($urandom_range(4, 0) != 0);
      n  = wl ? int'($urandom_range(DEPTH, 1)) : int'(DEPTH) + 1;
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_load(n, wl, 0, 3, 1'(($urandom_range(3, 0)) != 0), 1'($urandom_range(1, 0)));
    end

    @(negedge clk);
    chk("final_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
